// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// Produces pixel/line counters, blanking, sync and line/frame strobes from a
// double-buffered timing bank (shadow written by cfg port, copied into the
// active bank on the frame wrap). Sync positions accept signed offsets that
// wrap modulo the raster size and are sampled once per frame.
// Optional feature macro: VT_IRQ_EN enables the level vblank interrupt.
module video_timing_gen #(
  parameter int HW         = 9,
  parameter int VW         = 9,
  parameter int H_TOTAL    = 383,
  parameter int H_BL_START = 256,
  parameter int H_BL_END   = 0,
  parameter int H_S_START  = 264,
  parameter int H_S_END    = 296,
  parameter int V_TOTAL    = 261,
  parameter int V_BL_START = 240,
  parameter int V_BL_END   = 16,
  parameter int V_S_START  = 244,
  parameter int V_S_END    = 248
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [15:0]          cfg_wdata,
  input  logic                 cfg_commit,
  output logic                 cfg_pending,
  input  logic signed [HW-1:0] hs_offset,
  input  logic signed [VW-1:0] vs_offset,
  output logic [HW-1:0]        hc,
  output logic [VW-1:0]        vc,
  output logic                 hbl,
  output logic                 vbl,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 irq,
  input  logic                 irq_ack
);

  typedef struct packed {
    logic [HW-1:0] htot;
    logic [HW-1:0] hbls;
    logic [HW-1:0] hble;
    logic [HW-1:0] hss;
    logic [HW-1:0] hse;
    logic [VW-1:0] vtot;
    logic [VW-1:0] vbls;
    logic [VW-1:0] vble;
    logic [VW-1:0] vss;
    logic [VW-1:0] vse;
  } timing_t;

  localparam timing_t TIMING_DEF = '{
    htot: HW'(H_TOTAL),   hbls: HW'(H_BL_START), hble: HW'(H_BL_END),
    hss:  HW'(H_S_START), hse:  HW'(H_S_END),
    vtot: VW'(V_TOTAL),   vbls: VW'(V_BL_START), vble: VW'(V_BL_END),
    vss:  VW'(V_S_START), vse:  VW'(V_S_END)
  };

  localparam logic [HW-1:0] H_ONE = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] V_ONE = {{(VW-1){1'b0}}, 1'b1};

  // Effective horizontal position: start + offset, folded back into 0..total.
  function automatic logic [HW-1:0] eff_h(input logic [HW-1:0] start,
                                          input logic signed [HW-1:0] off,
                                          input logic [HW-1:0] total);
    logic signed [HW:0] e;
    logic signed [HW:0] span;
    e    = $signed({1'b0, start}) + $signed({off[HW-1], off});
    span = $signed({1'b0, total}) + $signed({{HW{1'b0}}, 1'b1});
    if (e[HW]) begin
      e = e + span;
    end else if (e > $signed({1'b0, total})) begin
      e = e - span;
    end else begin
      e = e;
    end
    return e[HW-1:0];
  endfunction

  // Effective vertical position: start + offset, folded back into 0..total.
  function automatic logic [VW-1:0] eff_v(input logic [VW-1:0] start,
                                          input logic signed [VW-1:0] off,
                                          input logic [VW-1:0] total);
    logic signed [VW:0] e;
    logic signed [VW:0] span;
    e    = $signed({1'b0, start}) + $signed({off[VW-1], off});
    span = $signed({1'b0, total}) + $signed({{VW{1'b0}}, 1'b1});
    if (e[VW]) begin
      e = e + span;
    end else if (e > $signed({1'b0, total})) begin
      e = e - span;
    end else begin
      e = e;
    end
    return e[VW-1:0];
  endfunction

  logic [HW-1:0]        h_q, h_d;
  logic [VW-1:0]        v_q, v_d;
  logic                 hbl_q, hbl_d, vbl_q, vbl_d;
  logic                 hs_q, hs_d, vs_q, vs_d;
  logic                 ls_q, ls_d, fs_q, fs_d;
  logic                 pend_q, pend_d;
  timing_t              act_q, act_d, sh_q, sh_d;
  logic signed [HW-1:0] hoff_q, hoff_d;
  logic signed [VW-1:0] voff_q, voff_d;

  logic                 wrap_h_s, wrap_f_s;
  logic [HW-1:0]        hs_set_s, hs_clr_s;
  logic [VW-1:0]        vs_set_s, vs_clr_s;

  assign wrap_h_s = ce && (h_q == act_q.htot);
  assign wrap_f_s = wrap_h_s && (v_q == act_q.vtot);
  assign hs_set_s = eff_h(act_q.hss, hoff_q, act_q.htot);
  assign hs_clr_s = eff_h(act_q.hse, hoff_q, act_q.htot);
  assign vs_set_s = eff_v(act_q.vss, voff_q, act_q.vtot);
  assign vs_clr_s = eff_v(act_q.vse, voff_q, act_q.vtot);

  // Counter and flag next-state: everything holds unless ce is high.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    hbl_d  = hbl_q;
    vbl_d  = vbl_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    if (ce) begin
      if (h_q == act_q.htot) begin
        h_d = {HW{1'b0}};
        if (v_q == act_q.vtot) begin
          v_d = {VW{1'b0}};
        end else begin
          v_d = v_q + V_ONE;
        end
      end else begin
        h_d = h_q + H_ONE;
        v_d = v_q;
      end
      // Set takes precedence so start==end leaves the flag high.
      if (h_q == act_q.hbls) begin
        hbl_d = 1'b1;
      end else if (h_q == act_q.hble) begin
        hbl_d = 1'b0;
      end else begin
        hbl_d = hbl_q;
      end
      if (h_q == hs_set_s) begin
        hs_d = 1'b1;
      end else if (h_q == hs_clr_s) begin
        hs_d = 1'b0;
      end else begin
        hs_d = hs_q;
      end
      // Vertical flags look at the line about to start.
      if (h_q == act_q.htot) begin
        if (v_d == act_q.vbls) begin
          vbl_d = 1'b1;
        end else if (v_d == act_q.vble) begin
          vbl_d = 1'b0;
        end else begin
          vbl_d = vbl_q;
        end
        if (v_d == vs_set_s) begin
          vs_d = 1'b1;
        end else if (v_d == vs_clr_s) begin
          vs_d = 1'b0;
        end else begin
          vs_d = vs_q;
        end
      end else begin
        vbl_d = vbl_q;
        vs_d  = vs_q;
      end
    end else begin
      h_d = h_q;
    end
  end

  // Strobes, config banks, commit handshake and per-frame offset sampling.
  always_comb begin
    ls_d   = wrap_h_s;
    fs_d   = wrap_f_s;
    sh_d   = sh_q;
    act_d  = act_q;
    hoff_d = hoff_q;
    voff_d = voff_q;
    // A new request on the commit edge stays pending for the next frame.
    if (cfg_commit) begin
      pend_d = 1'b1;
    end else if (wrap_f_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    // Copy uses the registered shadow, so a same-edge write misses this commit.
    if (wrap_f_s && pend_q) begin
      act_d = sh_q;
    end else begin
      act_d = act_q;
    end
    if (wrap_f_s) begin
      hoff_d = hs_offset;
      voff_d = vs_offset;
    end else begin
      hoff_d = hoff_q;
      voff_d = voff_q;
    end
    if (cfg_we) begin
      case (cfg_addr)
        4'd0:    sh_d.htot = cfg_wdata[HW-1:0];
        4'd1:    sh_d.hbls = cfg_wdata[HW-1:0];
        4'd2:    sh_d.hble = cfg_wdata[HW-1:0];
        4'd3:    sh_d.hss  = cfg_wdata[HW-1:0];
        4'd4:    sh_d.hse  = cfg_wdata[HW-1:0];
        4'd5:    sh_d.vtot = cfg_wdata[VW-1:0];
        4'd6:    sh_d.vbls = cfg_wdata[VW-1:0];
        4'd7:    sh_d.vble = cfg_wdata[VW-1:0];
        4'd8:    sh_d.vss  = cfg_wdata[VW-1:0];
        4'd9:    sh_d.vse  = cfg_wdata[VW-1:0];
        default: sh_d      = sh_q;
      endcase
    end else begin
      sh_d = sh_q;
    end
  end

  // State registers; reset restores default timing and drops pending commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q    <= {HW{1'b0}};
      v_q    <= {VW{1'b0}};
      hbl_q  <= 1'b0;
      vbl_q  <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      pend_q <= 1'b0;
      act_q  <= TIMING_DEF;
      sh_q   <= TIMING_DEF;
      hoff_q <= {HW{1'b0}};
      voff_q <= {VW{1'b0}};
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      hbl_q  <= hbl_d;
      vbl_q  <= vbl_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      hoff_q <= hoff_d;
      voff_q <= voff_d;
    end
  end

`ifdef VT_IRQ_EN
  logic irq_q, irq_d;
  logic unused_s;
  assign unused_s = ^cfg_wdata;

  // Interrupt level: set on the vbl rising ce, set beats a same-cycle ack.
  always_comb begin
    if (ce && vbl_d && !vbl_q) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Interrupt register.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_s;
  assign unused_s = ^{cfg_wdata, irq_ack};
  assign irq      = 1'b0;
`endif

  assign hc          = h_q;
  assign vc          = v_q;
  assign hbl         = hbl_q;
  assign vbl         = vbl_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. Horizontal timing is the default
// 384-pixel line; the vertical raster is shortened to 12 lines (blank 8..1,
// sync 9..9) so full frames stay short.
module tb_video_timing_gen;
  localparam int HW = 9;
  localparam int VW = 9;

  logic                 clk = 1'b0;
  logic                 reset, ce, cfg_we, cfg_commit, irq_ack;
  logic [3:0]           cfg_addr;
  logic [15:0]          cfg_wdata;
  logic signed [HW-1:0] hs_offset;
  logic signed [VW-1:0] vs_offset;
  logic                 cfg_pending, hbl, vbl, hsync, vsync;
  logic                 line_start, frame_start, irq;
  logic [HW-1:0]        hc;
  logic [VW-1:0]        vc;

  int checks   = 0;
  int failures = 0;
  bit quarter  = 1'b0;
  int phase    = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .V_TOTAL(11), .V_BL_START(8), .V_BL_END(2), .V_S_START(9), .V_S_END(10)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
    .hs_offset(hs_offset), .vs_offset(vs_offset), .hc(hc), .vc(vc),
    .hbl(hbl), .vbl(vbl), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .irq(irq),
    .irq_ack(irq_ack)
  );

  task automatic clk_step();
    @(posedge clk);
    #1;
    if (quarter) begin
      phase = (phase + 1) % 4;
      ce    = (phase == 0);
    end
  endtask

  task automatic wait_hv(input int th, input int tv, input int budget);
    int n = 0;
    while (!(hc == th && vc == tv) && n < budget) begin
      clk_step();
      n++;
    end
    checks++;
    if (!(hc == th && vc == tv)) begin
      failures++;
      $display("FAIL wait_hv: got h=%0d v=%0d, want h=%0d v=%0d", hc, vc, th, tv);
    end
  endtask

  task automatic wait_strobe(input bit frame_sel, input int budget, output int n);
    n = 0;
    do begin
      clk_step();
      n++;
    end while (!(frame_sel ? frame_start : line_start) && n < budget);
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; irq_ack = 1'b0;
    cfg_addr = 4'd0; cfg_wdata = 16'd0; hs_offset = 9'sd0; vs_offset = 9'sd0;
    repeat (3) clk_step();
    checks++;
    if ({hc, vc} !== 18'd0) begin
      failures++; $display("FAIL reset_counters: hc=%0d vc=%0d, want 0 0", hc, vc);
    end
    checks++;
    if ({hbl, vbl, hsync, vsync, line_start, frame_start, irq, cfg_pending} !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags: got %b, want 00000000",
               {hbl, vbl, hsync, vsync, line_start, frame_start, irq, cfg_pending});
    end
    reset = 1'b0;
  endtask

  task automatic test_line_period();
    int n;
    wait_strobe(1'b0, 1000, n);
    checks++;
    if (n != 384 || hc !== 9'd0 || vc !== 9'd1) begin
      failures++; $display("FAIL first_line: clocks=%0d hc=%0d vc=%0d, want 384 0 1", n, hc, vc);
    end
    clk_step();
    checks++;
    if (line_start !== 1'b0) begin
      failures++; $display("FAIL line_start_width: got %b, want 0", line_start);
    end
    wait_strobe(1'b0, 1000, n);
    checks++;
    if (n != 383) begin
      failures++; $display("FAIL line_period: got %0d, want 383", n);
    end
  endtask

  task automatic test_hflags();
    int n = 0;
    wait_hv(256, 2, 1000);
    checks++;
    if (hbl !== 1'b0) begin failures++; $display("FAIL hbl_before: got %b, want 0", hbl); end
    clk_step();
    checks++;
    if (hbl !== 1'b1) begin failures++; $display("FAIL hbl_rise: got %b, want 1", hbl); end
    wait_hv(264, 2, 1000);
    checks++;
    if (hsync !== 1'b0) begin failures++; $display("FAIL hsync_before: got %b, want 0", hsync); end
    clk_step();
    while (hsync === 1'b1 && n < 400) begin clk_step(); n++; end
    checks++;
    if (n != 32 || hc !== 9'd297) begin
      failures++; $display("FAIL hsync_width: got %0d ending hc=%0d, want 32 ending 297", n, hc);
    end
    wait_hv(0, 3, 1000);
    checks++;
    if (hbl !== 1'b1) begin failures++; $display("FAIL hbl_at_wrap: got %b, want 1", hbl); end
    clk_step();
    checks++;
    if (hbl !== 1'b0) begin failures++; $display("FAIL hbl_fall: got %b, want 0", hbl); end
  endtask

  task automatic test_frame();
    int n;
    wait_strobe(1'b1, 6000, n);
    wait_strobe(1'b1, 6000, n);
    checks++;
    if (n != 4608 || hc !== 9'd0 || vc !== 9'd0) begin
      failures++; $display("FAIL frame_period: clocks=%0d hc=%0d vc=%0d, want 4608 0 0", n, hc, vc);
    end
    wait_hv(0, 7, 6000);
    checks++;
    if (vbl !== 1'b0) begin failures++; $display("FAIL vbl_line7: got %b, want 0", vbl); end
    wait_hv(0, 8, 6000);
    checks++;
    if (vbl !== 1'b1) begin failures++; $display("FAIL vbl_line8: got %b, want 1", vbl); end
    wait_hv(0, 9, 6000);
    checks++;
    if (vsync !== 1'b1) begin failures++; $display("FAIL vsync_line9: got %b, want 1", vsync); end
    wait_hv(0, 10, 6000);
    checks++;
    if (vsync !== 1'b0) begin failures++; $display("FAIL vsync_line10: got %b, want 0", vsync); end
    wait_hv(0, 1, 6000);
    checks++;
    if (vbl !== 1'b1) begin failures++; $display("FAIL vbl_line1: got %b, want 1", vbl); end
    wait_hv(0, 2, 6000);
    checks++;
    if (vbl !== 1'b0) begin failures++; $display("FAIL vbl_line2: got %b, want 0", vbl); end
  endtask

  task automatic test_offsets();
    int n = 0;
    hs_offset = 9'sd100;
    vs_offset = -9'sd10;
    wait_strobe(1'b1, 6000, n);
    n = 0;
    wait_hv(364, 0, 1000);
    checks++;
    if (hsync !== 1'b0) begin failures++; $display("FAIL hs_off_before: got %b, want 0", hsync); end
    clk_step();
    checks++;
    if (hsync !== 1'b1) begin failures++; $display("FAIL hs_off_rise: got %b at hc=%0d, want 1", hsync, hc); end
    while (hsync === 1'b1 && n < 400) begin clk_step(); n++; end
    checks++;
    if (n != 32 || hc !== 9'd13) begin
      failures++; $display("FAIL hs_off_wrap: width=%0d ending hc=%0d, want 32 ending 13", n, hc);
    end
    wait_hv(0, 10, 6000);
    checks++;
    if (vsync !== 1'b0) begin failures++; $display("FAIL vs_off_line10: got %b, want 0", vsync); end
    wait_hv(0, 11, 6000);
    checks++;
    if (vsync !== 1'b1) begin failures++; $display("FAIL vs_off_line11: got %b, want 1", vsync); end
    hs_offset = 9'sd0;
    vs_offset = 9'sd0;
    wait_hv(0, 0, 6000);
    checks++;
    if (vsync !== 1'b0) begin failures++; $display("FAIL vs_off_line0: got %b, want 0", vsync); end
  endtask

  task automatic test_commit();
    int n;
    wait_hv(100, 3, 6000);
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_wdata = 16'd15; cfg_commit = 1'b1;
    clk_step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    checks++;
    if (cfg_pending !== 1'b1) begin failures++; $display("FAIL pending_set: got %b, want 1", cfg_pending); end
    wait_hv(383, 11, 6000);
    checks++;
    if (cfg_pending !== 1'b1) begin failures++; $display("FAIL pending_hold: got %b, want 1", cfg_pending); end
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_wdata = 16'd13; cfg_commit = 1'b1;
    clk_step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    checks++;
    if (hc !== 9'd0 || vc !== 9'd0 || frame_start !== 1'b1 || cfg_pending !== 1'b1) begin
      failures++;
      $display("FAIL commit_edge: hc=%0d vc=%0d fs=%b pend=%b, want 0 0 1 1", hc, vc, frame_start, cfg_pending);
    end
    wait_strobe(1'b1, 8000, n);
    checks++;
    if (n != 6144 || cfg_pending !== 1'b0) begin
      failures++; $display("FAIL frame16: clocks=%0d pend=%b, want 6144 0", n, cfg_pending);
    end
    wait_strobe(1'b1, 8000, n);
    checks++;
    if (n != 5376) begin failures++; $display("FAIL frame14: got %0d, want 5376", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    wait_hv(100, 5, 8000);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'd99; cfg_commit = 1'b1;
    clk_step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    checks++;
    if (cfg_pending !== 1'b1) begin failures++; $display("FAIL pend_before_reset: got %b, want 1", cfg_pending); end
    reset = 1'b1;
    clk_step();
    checks++;
    if ({hc, vc, hbl, vbl, hsync, vsync, line_start, frame_start, irq, cfg_pending} !== 26'd0) begin
      failures++;
      $display("FAIL mid_reset: hc=%0d vc=%0d flags=%b, want all 0", hc, vc,
               {hbl, vbl, hsync, vsync, line_start, frame_start, irq, cfg_pending});
    end
    reset = 1'b0;
    wait_strobe(1'b0, 1000, n);
    checks++;
    if (n != 384) begin failures++; $display("FAIL post_reset_line: got %0d, want 384", n); end
    wait_strobe(1'b1, 8000, n);
    checks++;
    if (n != 4224 || cfg_pending !== 1'b0) begin
      failures++; $display("FAIL post_reset_frame: clocks=%0d pend=%b, want 4224 0", n, cfg_pending);
    end
  endtask

  task automatic test_ce_quarter();
    int n;
    int frozen_bad = 0;
    logic [HW+VW+3:0] snap;
    logic prev_ce;
    quarter = 1'b1; phase = 0; ce = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      snap    = {hc, vc, hbl, vbl, hsync, vsync};
      prev_ce = ce;
      clk_step();
      if (!prev_ce && ({hc, vc, hbl, vbl, hsync, vsync} !== snap || line_start || frame_start))
        frozen_bad++;
    end
    checks++;
    if (frozen_bad != 0) begin
      failures++; $display("FAIL ce_freeze: %0d changes on ce=0 edges, want 0", frozen_bad);
    end
    wait_strobe(1'b0, 2000, n);
    wait_strobe(1'b0, 2000, n);
    checks++;
    if (n != 1536) begin failures++; $display("FAIL quarter_line: got %0d, want 1536", n); end
    quarter = 1'b0;
    ce = 1'b1;
  endtask

  task automatic test_irq();
`ifdef VT_IRQ_EN
    wait_hv(0, 6, 6000);
    irq_ack = 1'b1; clk_step(); irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_ack_clear: got %b, want 0", irq); end
    wait_hv(383, 7, 6000);
    irq_ack = 1'b1; clk_step(); irq_ack = 1'b0;
    checks++;
    if (vbl !== 1'b1 || irq !== 1'b1) begin
      failures++; $display("FAIL irq_set_wins: vbl=%b irq=%b, want 1 1", vbl, irq);
    end
    wait_hv(0, 9, 6000);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold: got %b, want 1", irq); end
    irq_ack = 1'b1; clk_step(); irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_ack: got %b, want 0", irq); end
`else
    wait_hv(0, 8, 6000);
    checks++;
    if (vbl !== 1'b1 || irq !== 1'b0) begin
      failures++; $display("FAIL irq_disabled: vbl=%b irq=%b, want 1 0", vbl, irq);
    end
    irq_ack = 1'b1; clk_step(); irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled_ack: got %b, want 0", irq); end
`endif
  endtask

  initial begin
    test_reset();
    test_line_period();
    test_hflags();
    test_frame();
    test_offsets();
    test_commit();
    test_reset_mid();
    test_ce_quarter();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
